// File: rtl/keccak_pkg.sv
// Shared Keccak definitions for the padding front end.
// Provides the standard rate widths, the domain-separation bytes, the
// padder FSM state type and a small width helper used for counters.
package keccak_pkg;

  // Rate (block width) in bits for each supported instance.
  localparam int SHA3_256_RATE = 1088;
  localparam int SHA3_512_RATE = 576;
  localparam int SHAKE128_RATE = 1344;
  localparam int SHAKE256_RATE = 1088;

  // Domain-separation bytes, already combined with the first pad bit.
  localparam logic [7:0] DS_SHA3  = 8'h06;
  localparam logic [7:0] DS_SHAKE = 8'h1F;

  // Final pad bit of the multi-rate padding, always in the last rate byte.
  localparam logic [7:0] PAD_END_BYTE = 8'h80;

  // Padder states: collecting words, or presenting a finished block.
  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_EMIT = 1'b1
  } pad_state_e;

  // Counter width that stays at least one bit for degenerate sizes.
  function automatic int clog2_min1(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/keccak_pad_lane.sv
// Combinational per-word padding helper.
// Masks the unused tail bytes of a final word and works out where the
// domain-separation byte lands inside the rate block.
//   i_word        incoming message word, first byte in the top 8 bits
//   i_bytes       valid byte count (only meaningful on the last word)
//   i_last        word ends the message
//   i_wcnt        word slot inside the current block
//   o_word        word with bytes at or beyond the message end zeroed
//   o_ds_pos      byte index in the block where DS_BYTE is OR-ed in
//   o_ds_en       padding fits in this block (DS at o_ds_pos, 0x80 at RB-1)
//   o_pad_pending last word filled the block exactly; a pad-only block follows
module keccak_pad_lane
  import keccak_pkg::*;
#(
  parameter int RATE_BITS = 576,
  parameter int WORD_BITS = 64,
  localparam int WB       = WORD_BITS / 8,
  localparam int RB       = RATE_BITS / 8,
  localparam int NW       = RATE_BITS / WORD_BITS,
  localparam int CNT_W    = clog2_min1(NW),
  localparam int IB_W     = $clog2(WB) + 1,
  localparam int POS_W    = $clog2(RB + 1)
) (
  input  logic [WORD_BITS-1:0] i_word,
  input  logic [IB_W-1:0]      i_bytes,
  input  logic                 i_last,
  input  logic [CNT_W-1:0]     i_wcnt,
  output logic [WORD_BITS-1:0] o_word,
  output logic [POS_W-1:0]     o_ds_pos,
  output logic                 o_ds_en,
  output logic                 o_pad_pending
);

  logic [IB_W-1:0]  w_nbytes;
  logic [POS_W-1:0] w_pos;

  // Effective byte count: full for non-last words, clamped to WB otherwise.
  always_comb begin
    w_nbytes = IB_W'(WB);
    if (!i_last) begin
      w_nbytes = IB_W'(WB);
    end else if (i_bytes > IB_W'(WB)) begin
      w_nbytes = IB_W'(WB);
    end else begin
      w_nbytes = i_bytes;
    end
  end

  // Zero every byte at or past the message end so garbage never reaches the block.
  always_comb begin
    o_word = '0;
    for (int b = 0; b < WB; b++) begin
      o_word[WORD_BITS-1-8*b -: 8] = (IB_W'(b) < w_nbytes) ?
                                     i_word[WORD_BITS-1-8*b -: 8] : 8'h00;
    end
  end

  // Message length within the block after this word; p == RB means no room for padding.
  assign w_pos         = (POS_W'(i_wcnt) * POS_W'(WB)) + POS_W'(w_nbytes);
  assign o_ds_pos      = w_pos;
  assign o_ds_en       = i_last && (w_pos < POS_W'(RB));
  assign o_pad_pending = i_last && (w_pos == POS_W'(RB));

endmodule

// File: rtl/keccak_stream_padder.sv
// Streaming Keccak multi-rate padder.
// Packs a byte-granular message stream into RATE_BITS blocks, appends the
// DS_BYTE ... 0x80 padding and hands blocks to the absorb stage.
//   clk        clock, all state on the rising edge
//   reset      synchronous active-low reset
//   in         message word, first byte in the top 8 bits
//   in_valid   word present
//   in_last    word ends the message
//   in_bytes   valid bytes in a last word (clamped to WORD_BITS/8)
//   in_ready   padder accepts a word (state only, low during reset)
//   out        registered padded block, byte 0 in the top 8 bits
//   out_valid  out holds a complete block
//   out_last   block is the final block of the message
//   out_ready  downstream consumes the block
module keccak_stream_padder
  import keccak_pkg::*;
#(
  parameter int         RATE_BITS = 576,
  parameter int         WORD_BITS = 64,
  parameter logic [7:0] DS_BYTE   = DS_SHA3,
  localparam int        WB        = WORD_BITS / 8,
  localparam int        RB        = RATE_BITS / 8,
  localparam int        NW        = RATE_BITS / WORD_BITS,
  localparam int        CNT_W     = clog2_min1(NW),
  localparam int        IB_W      = $clog2(WB) + 1,
  localparam int        POS_W     = $clog2(RB + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_BITS-1:0] in,
  input  logic                 in_valid,
  input  logic                 in_last,
  input  logic [IB_W-1:0]      in_bytes,
  output logic                 in_ready,
  output logic [RATE_BITS-1:0] out,
  output logic                 out_valid,
  output logic                 out_last,
  input  logic                 out_ready
);

  // Block sent after a message that exactly fills a block.
  localparam logic [RATE_BITS-1:0] PAD_ONLY_BLOCK =
    {DS_BYTE, {(RATE_BITS-16){1'b0}}, PAD_END_BYTE};

  pad_state_e           r_state;
  logic [CNT_W-1:0]     r_wcnt;
  logic                 r_pad_pending;
  logic [RATE_BITS-1:0] r_buf;
  logic                 r_out_valid;
  logic                 r_out_last;

  logic [WORD_BITS-1:0] w_lane_word;
  logic [POS_W-1:0]     w_ds_pos;
  logic                 w_ds_en;
  logic                 w_pad_pending;
  logic [RATE_BITS-1:0] w_buf_next;

  keccak_pad_lane #(
    .RATE_BITS (RATE_BITS),
    .WORD_BITS (WORD_BITS)
  ) u_lane (
    .i_word        (in),
    .i_bytes       (in_bytes),
    .i_last        (in_last),
    .i_wcnt        (r_wcnt),
    .o_word        (w_lane_word),
    .o_ds_pos      (w_ds_pos),
    .o_ds_en       (w_ds_en),
    .o_pad_pending (w_pad_pending)
  );

  // Buffer image after accepting the current word, including padding bytes when they fit.
  always_comb begin
    w_buf_next = r_buf;
    for (int k = 0; k < NW; k++) begin
      w_buf_next[RATE_BITS-1-WORD_BITS*k -: WORD_BITS] =
        (r_wcnt == CNT_W'(k)) ? w_lane_word : r_buf[RATE_BITS-1-WORD_BITS*k -: WORD_BITS];
    end
    for (int b = 0; b < RB; b++) begin
      w_buf_next[RATE_BITS-1-8*b -: 8] = w_buf_next[RATE_BITS-1-8*b -: 8] |
        ((w_ds_en && (w_ds_pos == POS_W'(b))) ? DS_BYTE : 8'h00);
    end
    // OR rather than overwrite so p == RB-1 merges into DS_BYTE | 0x80.
    w_buf_next[7:0] = w_buf_next[7:0] | (w_ds_en ? PAD_END_BYTE : 8'h00);
  end

  // Padder FSM: word counter, block buffer, pending pad block and output flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= ST_FILL;
      r_wcnt        <= '0;
      r_pad_pending <= 1'b0;
      r_buf         <= '0;
      r_out_valid   <= 1'b0;
      r_out_last    <= 1'b0;
    end else begin
      case (r_state)
        ST_FILL: begin
          if (in_valid) begin
            r_buf <= w_buf_next;
            if (in_last) begin
              r_state       <= ST_EMIT;
              r_wcnt        <= '0;
              r_out_valid   <= 1'b1;
              r_out_last    <= ~w_pad_pending;
              r_pad_pending <= w_pad_pending;
            end else if (r_wcnt == CNT_W'(NW - 1)) begin
              r_state     <= ST_EMIT;
              r_wcnt      <= '0;
              r_out_valid <= 1'b1;
              r_out_last  <= 1'b0;
            end else begin
              r_wcnt <= r_wcnt + CNT_W'(1);
            end
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            if (r_pad_pending) begin
              r_buf         <= PAD_ONLY_BLOCK;
              r_pad_pending <= 1'b0;
              r_out_last    <= 1'b1;
            end else begin
              r_state     <= ST_FILL;
              r_buf       <= '0;
              r_wcnt      <= '0;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
            end
          end
        end
        default: begin
          r_state       <= ST_FILL;
          r_wcnt        <= '0;
          r_pad_pending <= 1'b0;
          r_buf         <= '0;
          r_out_valid   <= 1'b0;
          r_out_last    <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = reset && (r_state == ST_FILL);
  assign out       = r_buf;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_keccak_stream_padder.sv
module tb_keccak_stream_padder;
  import keccak_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [63:0] in_w;
  logic        in_valid, in_last, out_ready;
  logic [3:0]  in_bytes;
  int          sel;

  logic [2:0]    iv_g, or_g;
  logic          rdy_a, rdy_b, rdy_c, ov_a, ov_b, ov_c, ol_a, ol_b, ol_c;
  logic [575:0]  out_a, out_b;
  logic [1343:0] out_c;

  logic          m_ready, m_ov, m_ol;
  logic [1343:0] m_out;

  int n_checks = 0;
  int n_errors = 0;

  // Route handshakes to the selected instance only.
  always_comb begin
    iv_g = 3'b000;
    or_g = 3'b000;
    iv_g[sel] = in_valid;
    or_g[sel] = out_ready;
  end

  always_comb begin
    case (sel)
      0:       begin m_ready = rdy_a; m_ov = ov_a; m_ol = ol_a; m_out = {out_a, 768'h0}; end
      1:       begin m_ready = rdy_b; m_ov = ov_b; m_ol = ol_b; m_out = {out_b, 768'h0}; end
      default: begin m_ready = rdy_c; m_ov = ov_c; m_ol = ol_c; m_out = out_c; end
    endcase
  end

  keccak_stream_padder #(.RATE_BITS(576), .WORD_BITS(64), .DS_BYTE(8'h06)) dut_a (
    .clk(clk), .reset(reset), .in(in_w), .in_valid(iv_g[0]), .in_last(in_last),
    .in_bytes(in_bytes), .in_ready(rdy_a), .out(out_a), .out_valid(ov_a),
    .out_last(ol_a), .out_ready(or_g[0]));

  keccak_stream_padder #(.RATE_BITS(576), .WORD_BITS(64), .DS_BYTE(8'h1F)) dut_b (
    .clk(clk), .reset(reset), .in(in_w), .in_valid(iv_g[1]), .in_last(in_last),
    .in_bytes(in_bytes), .in_ready(rdy_b), .out(out_b), .out_valid(ov_b),
    .out_last(ol_b), .out_ready(or_g[1]));

  keccak_stream_padder #(.RATE_BITS(1344), .WORD_BITS(64), .DS_BYTE(8'h1F)) dut_c (
    .clk(clk), .reset(reset), .in(in_w), .in_valid(iv_g[2]), .in_last(in_last),
    .in_bytes(in_bytes), .in_ready(rdy_c), .out(out_c), .out_valid(ov_c),
    .out_last(ol_c), .out_ready(or_g[2]));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic check_blk(input string tag, input logic [1343:0] obs, input logic [1343:0] exp);
    for (int k = 0; k < 21; k++)
      check($sformatf("%s[%0d]", tag, k), obs[1343-64*k -: 64], exp[1343-64*k -: 64]);
  endtask

  // Drive one message to instance s and score its blocks against the padding rule.
  task automatic send_msg(input int s, input int len, input int stall, input bit clamp);
    byte unsigned msg[$];
    byte unsigned pad[$];
    int rb, nw_blk, nwords, wi, bi, nblk, stall_cnt, cyc, nb;
    logic [7:0]    ds;
    logic [1343:0] exp_blk;
    logic [63:0]   word;
    bit            expect_ov;
    rb     = (s == 2) ? 168 : 72;
    ds     = (s == 0) ? 8'h06 : 8'h1F;
    nw_blk = rb / 8;
    for (int i = 0; i < len; i++) msg.push_back(8'($urandom_range(0, 255)));
    // Keccak pad10*1: DS right after the message, 0x80 in the last byte of the final block.
    pad = msg;
    pad.push_back(ds);
    while (pad.size() % rb != 0) pad.push_back(8'h00);
    pad[pad.size()-1] = pad[pad.size()-1] | 8'h80;
    nblk   = pad.size() / rb;
    nwords = (len == 0) ? 1 : (len + 7) / 8;
    sel = s; wi = 0; bi = 0; stall_cnt = 0; cyc = 0; expect_ov = 1'b0;
    while (bi < nblk && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (expect_ov) check("latency_out_valid", 64'(m_ov), 64'd1);
      expect_ov = 1'b0;
      if (cyc == 1) check("in_ready_first", 64'(m_ready), 64'd1);
      exp_blk = '0;
      for (int i = 0; i < rb; i++) exp_blk[1343-8*i -: 8] = pad[bi*rb+i];
      in_valid = (wi < nwords);
      if (wi < nwords) begin
        nb = (wi == nwords - 1) ? len - wi * 8 : 8;
        for (int j = 0; j < 8; j++)
          word[63-8*j -: 8] = (j < nb) ? msg[wi*8+j] : 8'($urandom_range(0, 255));
        in_w     = word;
        in_last  = (wi == nwords - 1);
        in_bytes = (clamp && in_last && nb == 8) ? 4'($urandom_range(9, 15)) : 4'(nb);
      end else begin
        in_w = 64'($urandom); in_last = 1'($urandom); in_bytes = 4'($urandom);
      end
      out_ready = (stall_cnt >= stall);
      if (m_ov) begin
        check_blk($sformatf("block%0d", bi), m_out, exp_blk);
        check("out_last", 64'(m_ol), 64'(bi == nblk - 1));
        check("in_ready_emit", 64'(m_ready), 64'd0);
      end
      if (in_valid && m_ready) begin
        if (wi == nwords - 1 || (wi % nw_blk) == nw_blk - 1) expect_ov = 1'b1;
        wi++;
      end
      if (m_ov) begin
        if (out_ready) begin bi++; stall_cnt = 0; end
        else stall_cnt++;
      end
    end
    check("blocks_done", 64'(bi), 64'(nblk));
  endtask

  task automatic check_idle_all(input string tag);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check({tag, "_ov"}, 64'(m_ov), 64'd0);
      check({tag, "_ol"}, 64'(m_ol), 64'd0);
      check({tag, "_rdy"}, 64'(m_ready), 64'd1);
      check_blk({tag, "_out"}, m_out, '0);
    end
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_bytes = 4'd0;
    in_w = 64'd0; out_ready = 1'b0; sel = 0;
    repeat (3) @(negedge clk);
    check("in_ready_in_reset", 64'(m_ready), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check_idle_all("reset_state");
    sel = 0;

    // Directed cases from the padding rules.
    send_msg(0, 64, 0, 1'b0);
    send_msg(0, 32, 0, 1'b0);
    send_msg(0, 0, 0, 1'b0);
    send_msg(0, 71, 0, 1'b0);
    send_msg(1, 71, 0, 1'b0);
    send_msg(0, 72, 0, 1'b0);
    send_msg(2, 200, 5, 1'b0);
    send_msg(0, 16, 0, 1'b1);
    send_msg(2, 168, 2, 1'b1);

    // Reset three words into a message: nothing must come out, no residue after.
    @(negedge clk);
    sel = 0; out_ready = 1'b1;
    for (int w = 0; w < 3; w++) begin
      if (w > 0) @(negedge clk);
      in_valid = 1'b1; in_last = 1'b0; in_bytes = 4'd8; in_w = {$urandom, $urandom};
      check("pre_reset_ready", 64'(m_ready), 64'd1);
    end
    @(negedge clk);
    in_valid = 1'b0; reset = 1'b0;
    check("pre_reset_ov", 64'(m_ov), 64'd0);
    @(negedge clk);
    check("mid_reset_ov", 64'(m_ov), 64'd0);
    check("mid_reset_rdy", 64'(m_ready), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check_idle_all("post_reset");
    sel = 0;
    send_msg(0, 32, 0, 1'b0);

    // Randomised messages across all three configurations.
    for (int t = 0; t < 30; t++)
      send_msg($urandom_range(0, 2), $urandom_range(0, 400), $urandom_range(0, 3), 1'($urandom));

    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
